// File: rtl/blowfish128_pkg.sv
// Shared Blowfish-128 types: FSM state encoding, half-block and subkey word types.
package blowfish128_pkg;

    localparam int BF128_ROUNDS = 8;
    localparam int BF128_HALF_W = 64;

    typedef logic [31:0]             subkey_t;
    typedef logic [BF128_HALF_W-1:0] half_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XORK,
        ST_FREQ,
        ST_FWAIT,
        ST_FINAL
    } state_t;

endpackage

// File: rtl/blowfish128_dec_keysel.sv
// Decryption key schedule mux: round r uses K(10-r); K1/K2 feed the output whitening.
module blowfish128_dec_keysel
    import blowfish128_pkg::*;
(
    input  logic [3:0] i_round,
    input  subkey_t    i_p [0:19],
    output half_t      o_kround,
    output half_t      o_k1,
    output half_t      o_k2
);

    // K_i = {P(2i-1), P(2i)}, with P1 at index 0
    always_comb begin
        o_kround = '0;
        case (i_round)
            4'd0:    o_kround = {i_p[18], i_p[19]};
            4'd1:    o_kround = {i_p[16], i_p[17]};
            4'd2:    o_kround = {i_p[14], i_p[15]};
            4'd3:    o_kround = {i_p[12], i_p[13]};
            4'd4:    o_kround = {i_p[10], i_p[11]};
            4'd5:    o_kround = {i_p[8],  i_p[9]};
            4'd6:    o_kround = {i_p[6],  i_p[7]};
            4'd7:    o_kround = {i_p[4],  i_p[5]};
            default: o_kround = '0;
        endcase
    end

    assign o_k1 = {i_p[0], i_p[1]};
    assign o_k2 = {i_p[2], i_p[3]};

endmodule

// File: rtl/blowfish128_decrypt_core.sv
// Iterative Blowfish-128 decryption core sharing an external F unit via X/Y handshake.
// Define BLOWFISH128_DEC_KEYCHK_EN to abort a block when skey_ready drops mid-block.
module blowfish128_decrypt_core
    import blowfish128_pkg::*;
#(
    parameter int ROUNDS = BF128_ROUNDS
)
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Enable,
    input  logic [127:0] cipherText,
    output logic [127:0] plainText,
    output logic         plainReady,
    input  logic         skey_ready,
    input  subkey_t      P1,  P2,  P3,  P4,  P5,  P6,  P7,  P8,  P9,  P10,
    input  subkey_t      P11, P12, P13, P14, P15, P16, P17, P18, P19, P20,
    output half_t        X,
    output logic         ffunc_enable,
    input  half_t        Y,
    input  logic         ffunc_ready
);

    state_t       r_state, w_state_nx;
    half_t        r_lh, r_rh, w_lh_nx, w_rh_nx;
    logic [3:0]   r_cnt, w_cnt_nx;
    logic [127:0] r_pt, w_pt_nx;
    logic         r_prdy, w_prdy_nx;
    logic         w_keyok;
    half_t        w_kround, w_k1, w_k2;
    subkey_t      w_p [0:19];

    assign w_p = '{P1, P2, P3, P4, P5, P6, P7, P8, P9, P10,
                   P11, P12, P13, P14, P15, P16, P17, P18, P19, P20};

    blowfish128_dec_keysel u_keysel (
        .i_round  (r_cnt),
        .i_p      (w_p),
        .o_kround (w_kround),
        .o_k1     (w_k1),
        .o_k2     (w_k2)
    );

`ifdef BLOWFISH128_DEC_KEYCHK_EN
    assign w_keyok = skey_ready;
`else
    assign w_keyok = 1'b1;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_lh_nx      = r_lh;
        w_rh_nx      = r_rh;
        w_cnt_nx     = r_cnt;
        w_pt_nx      = r_pt;
        w_prdy_nx    = 1'b0;
        ffunc_enable = 1'b0;
        X            = '0;
        case (r_state)
            ST_IDLE: begin
                if (Enable && skey_ready) begin
                    w_lh_nx    = cipherText[127:64];
                    w_rh_nx    = cipherText[63:0];
                    w_cnt_nx   = '0;
                    w_state_nx = ST_XORK;
                end
            end
            ST_XORK: begin
                w_lh_nx    = r_lh ^ w_kround;
                w_state_nx = ST_FREQ;
            end
            ST_FREQ: begin
                ffunc_enable = 1'b1;
                X            = r_lh;
                w_state_nx   = ST_FWAIT;
            end
            ST_FWAIT: begin
                X = r_lh;
                if (ffunc_ready) begin
                    w_lh_nx = r_rh ^ Y;
                    w_rh_nx = r_lh;
                    if (r_cnt == 4'(ROUNDS - 1)) begin
                        w_state_nx = ST_FINAL;
                    end else begin
                        w_cnt_nx   = r_cnt + 4'd1;
                        w_state_nx = ST_XORK;
                    end
                end
            end
            ST_FINAL: begin
                // registers still hold the last round's swap, so halves are crossed here
                w_pt_nx    = {r_rh ^ w_k1, r_lh ^ w_k2};
                w_prdy_nx  = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && !w_keyok) begin
            w_state_nx = ST_IDLE;
            w_lh_nx    = r_lh;
            w_rh_nx    = r_rh;
            w_cnt_nx   = r_cnt;
            w_pt_nx    = r_pt;
            w_prdy_nx  = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_lh    <= '0;
            r_rh    <= '0;
            r_cnt   <= '0;
            r_pt    <= '0;
            r_prdy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_lh    <= w_lh_nx;
            r_rh    <= w_rh_nx;
            r_cnt   <= w_cnt_nx;
            r_pt    <= w_pt_nx;
            r_prdy  <= w_prdy_nx;
        end
    end

    assign plainText  = r_pt;
    assign plainReady = r_prdy;

endmodule
